pc_unit: RTL and testbench

Parametrised program-counter unit with an integrated return-address stack. It generalises the fixed 16-bit incrementer into a registered PC of configurable width that supports increment, absolute load, call (push and jump) and return (pop). It also detects wrap-around and stack overflow and underflow. It sits in the CPU fetch path and drives the instruction-memory address.

---
 rtl/pc_pkg.sv | 35 +++
 rtl/pc_unit_incn.sv | 25 ++
 rtl/pc_unit.sv | 124 ++++++++++++
 tb/tb_pc_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and command decode for the program-counter unit.
// Optional build macro: PC_SAT_EN (saturating increment).
package pc_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int CNT_W     = $clog2(DEPTH_DEF) + 1;

    typedef enum logic [2:0] {
        CMD_HOLD,
        CMD_INC,
        CMD_LOAD,
        CMD_CALL,
        CMD_RET
    } cmd_e;

    // Fixed priority: ret > call > load > inc.
    function automatic cmd_e pc_decode(
        input logic ret,
        input logic call,
        input logic load,
        input logic inc
    );
        cmd_e c;
        c = CMD_HOLD;
        priority case (1'b1)
            ret:     c = CMD_RET;
            call:    c = CMD_CALL;
            load:    c = CMD_LOAD;
            inc:     c = CMD_INC;
            default: c = CMD_HOLD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pc_unit_incn.sv
// WIDTH-bit +1 incrementer with carry-out.
// With PC_SAT_EN defined, i_sat holds all-ones instead of wrapping.
module incn #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic             i_sat,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_co
);

    logic [WIDTH:0] w_full;

    assign w_full = {1'b0, i_a} + {{WIDTH{1'b0}}, 1'b1};
    assign o_co   = w_full[WIDTH];

`ifdef PC_SAT_EN
    assign o_sum = (i_sat && w_full[WIDTH]) ? i_a : w_full[WIDTH-1:0];
`else
    logic w_unused_sat;
    assign w_unused_sat = i_sat;
    assign o_sum        = w_full[WIDTH-1:0];
`endif

endmodule

// File: rtl/pc_unit.sv
// Registered program counter with an integrated return-address stack.
// Build option PC_SAT_EN: increments from all-ones saturate instead of wrapping.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             inc,
    input  logic             load,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] addr,
    input  logic             err_clr,
    output logic [WIDTH-1:0] pc,
    output logic             ovf,
    output logic             stk_full,
    output logic             stk_empty,
    output logic             stk_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_pc;
    logic             r_ovf;
    logic             r_err;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_stk [DEPTH];

    cmd_e             w_cmd;
    logic [WIDTH-1:0] w_pc_inc;
    logic             w_pc_co;
    logic [WIDTH-1:0] w_push;
    logic             w_push_co;
    logic             w_full;
    logic             w_empty;
    logic             w_err_set;
    logic             w_do_push;
    logic [AW-1:0]    w_top_idx;

    assign w_cmd = pc_decode(ret, call, load, inc);

    incn #(.WIDTH(WIDTH)) u_inc_pc (
        .i_a   (r_pc),
        .i_sat (1'b1),
        .o_sum (w_pc_inc),
        .o_co  (w_pc_co)
    );

    // Return address never raises ovf, so its carry is dropped.
    incn #(.WIDTH(WIDTH)) u_inc_push (
        .i_a   (r_pc),
        .i_sat (1'b1),
        .o_sum (w_push),
        .o_co  (w_push_co)
    );

    logic w_unused_co;
    assign w_unused_co = w_push_co;

    assign w_full    = (r_cnt == CW'(DEPTH));
    assign w_empty   = (r_cnt == '0);
    assign w_top_idx = r_cnt[AW-1:0] - 1'b1;
    assign w_do_push = en && (w_cmd == CMD_CALL) && !w_full;
    assign w_err_set = en && (((w_cmd == CMD_CALL) && w_full) ||
                              ((w_cmd == CMD_RET) && w_empty));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc  <= RESET_PC;
            r_ovf <= 1'b0;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_ovf <= 1'b0;
            if (w_err_set)
                r_err <= 1'b1;
            else if (err_clr)
                r_err <= 1'b0;
            if (en) begin
                unique case (w_cmd)
                    CMD_INC: begin
                        r_pc  <= w_pc_inc;
                        r_ovf <= w_pc_co;
                    end
                    CMD_LOAD: r_pc <= addr;
                    CMD_CALL: begin
                        r_pc <= addr;
                        if (!w_full)
                            r_cnt <= r_cnt + 1'b1;
                    end
                    CMD_RET: begin
                        if (!w_empty) begin
                            r_pc  <= r_stk[w_top_idx];
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            r_pc  <= w_pc_inc;
                            r_ovf <= w_pc_co;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Storage contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (w_do_push)
            r_stk[r_cnt[AW-1:0]] <= w_push;
    end

    assign pc        = r_pc;
    assign ovf       = r_ovf;
    assign stk_err   = r_err;
    assign stk_full  = w_full;
    assign stk_empty = w_empty;

endmodule

// File: tb/tb_pc_unit.sv
// Directed table-driven bench for pc_unit (WIDTH=16, DEPTH=4, RESET_PC=0x0100).
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, inc, load, call, ret, err_clr;
    logic [15:0] addr;
    logic [15:0] pc;
    logic        ovf, stk_full, stk_empty, stk_err;

    int n_chk = 0;
    int n_pass = 0;

`ifdef PC_SAT_EN
    localparam logic [15:0] WRAP = 16'hFFFF;
`else
    localparam logic [15:0] WRAP = 16'h0000;
`endif

    always #5 clk = ~clk;

    pc_unit #(
        .WIDTH    (16),
        .DEPTH    (4),
        .RESET_PC (16'h0100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .inc       (inc),
        .load      (load),
        .call      (call),
        .ret       (ret),
        .addr      (addr),
        .err_clr   (err_clr),
        .pc        (pc),
        .ovf       (ovf),
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
        .stk_err   (stk_err)
    );

    typedef struct {
        logic        en, inc, load, call, ret, clr;
        logic [15:0] addr;
        logic [15:0] pc;
        logic        ovf, full, empty, err;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(
        input logic en_i, input logic inc_i, input logic ld_i,
        input logic cl_i, input logic rt_i, input logic clr_i,
        input logic [15:0] a_i, input logic [15:0] pc_i,
        input logic ovf_i, input logic full_i,
        input logic empty_i, input logic err_i
    );
        vec_t r;
        r.en = en_i; r.inc = inc_i; r.load = ld_i;
        r.call = cl_i; r.ret = rt_i; r.clr = clr_i;
        r.addr = a_i; r.pc = pc_i; r.ovf = ovf_i;
        r.full = full_i; r.empty = empty_i; r.err = err_i;
        return r;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [15:0] got, input logic [15:0] want);
        n_chk++;
        if (got === want)
            n_pass++;
        else
            $display("FAIL %s step %0d: got %h want %h", name, idx, got, want);
    endtask

    task automatic check_all(input int idx, input logic [15:0] e_pc,
                             input logic e_ovf, input logic e_full,
                             input logic e_empty, input logic e_err);
        chk("pc", idx, pc, e_pc);
        chk("ovf", idx, {15'd0, ovf}, {15'd0, e_ovf});
        chk("stk_full", idx, {15'd0, stk_full}, {15'd0, e_full});
        chk("stk_empty", idx, {15'd0, stk_empty}, {15'd0, e_empty});
        chk("stk_err", idx, {15'd0, stk_err}, {15'd0, e_err});
    endtask

    task automatic drive(input vec_t x);
        en = x.en; inc = x.inc; load = x.load;
        call = x.call; ret = x.ret; err_clr = x.clr;
        addr = x.addr;
    endtask

    initial begin
        //        en i l c r clr addr      pc        ovf f e err
        vq.push_back(v(1,1,0,0,0,0,16'h0000,16'h0101,0,0,1,0));
        vq.push_back(v(1,1,0,0,0,0,16'h0000,16'h0102,0,0,1,0));
        vq.push_back(v(1,1,0,0,0,0,16'h0000,16'h0103,0,0,1,0));
        vq.push_back(v(1,0,1,0,0,0,16'hFFFF,16'hFFFF,0,0,1,0));
        vq.push_back(v(1,1,0,0,0,0,16'h0000,WRAP,    1,0,1,0));
        vq.push_back(v(1,0,0,0,0,0,16'h0000,WRAP,    0,0,1,0));
        vq.push_back(v(1,0,1,0,0,0,16'h0010,16'h0010,0,0,1,0));
        vq.push_back(v(1,0,0,1,0,0,16'h0200,16'h0200,0,0,0,0));
        vq.push_back(v(1,0,0,1,0,0,16'h0300,16'h0300,0,0,0,0));
        vq.push_back(v(1,0,0,0,1,0,16'h0000,16'h0201,0,0,0,0));
        vq.push_back(v(1,0,0,0,1,0,16'h0000,16'h0011,0,0,1,0));
        vq.push_back(v(1,0,1,0,0,0,16'h0040,16'h0040,0,0,1,0));
        vq.push_back(v(1,0,0,0,1,0,16'h0000,16'h0041,0,0,1,1));
        vq.push_back(v(1,0,0,0,0,1,16'h0000,16'h0041,0,0,1,0));
        vq.push_back(v(1,0,0,0,1,1,16'h0000,16'h0042,0,0,1,1));
        vq.push_back(v(1,0,0,0,0,1,16'h0000,16'h0042,0,0,1,0));
        vq.push_back(v(0,1,1,0,0,0,16'h1234,16'h0042,0,0,1,0));
        vq.push_back(v(0,0,0,1,0,0,16'h1234,16'h0042,0,0,1,0));
        vq.push_back(v(1,1,1,1,0,0,16'h0500,16'h0500,0,0,0,0));
        vq.push_back(v(1,0,0,0,1,0,16'h0000,16'h0043,0,0,1,0));
        vq.push_back(v(1,0,0,1,0,0,16'h1000,16'h1000,0,0,0,0));
        vq.push_back(v(1,0,0,1,0,0,16'h2000,16'h2000,0,0,0,0));
        vq.push_back(v(1,0,0,1,0,0,16'h3000,16'h3000,0,0,0,0));
        vq.push_back(v(1,0,0,1,0,0,16'h4000,16'h4000,0,1,0,0));
        vq.push_back(v(1,0,0,1,0,0,16'h5000,16'h5000,0,1,0,1));
        vq.push_back(v(1,0,0,0,1,0,16'h0000,16'h3001,0,0,0,1));
        vq.push_back(v(1,0,0,0,1,0,16'h0000,16'h2001,0,0,0,1));
        vq.push_back(v(1,0,0,0,1,0,16'h0000,16'h1001,0,0,0,1));
        vq.push_back(v(1,0,0,0,1,0,16'h0000,16'h0044,0,0,1,1));
        vq.push_back(v(0,0,0,0,0,1,16'h0000,16'h0044,0,0,1,0));
        vq.push_back(v(1,0,1,0,0,0,16'hFFFF,16'hFFFF,0,0,1,0));
        vq.push_back(v(1,0,0,0,1,0,16'h0000,WRAP,    1,0,1,1));
        vq.push_back(v(0,1,0,0,0,0,16'h0000,WRAP,    0,0,1,1));
        vq.push_back(v(1,0,1,0,0,1,16'h0000,16'h0000,0,0,1,0));
        vq.push_back(v(1,0,0,1,0,0,16'h0700,16'h0700,0,0,0,0));

        rst_n = 1'b0;
        en = 0; inc = 0; load = 0; call = 0; ret = 0;
        err_clr = 0; addr = '0;
        repeat (3) @(negedge clk);
        check_all(0, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            @(posedge clk);
            #1;
            check_all(i + 1, vq[i].pc, vq[i].ovf, vq[i].full,
                      vq[i].empty, vq[i].err);
            @(negedge clk);
        end

        // Asynchronous reset between edges with a pushed entry pending.
        en = 1; inc = 0; load = 0; call = 0; ret = 0; err_clr = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all(100, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        inc = 1;
        @(posedge clk);
        #1;
        check_all(101, 16'h0101, 1'b0, 1'b0, 1'b1, 1'b0);

        // Call immediately followed by ret returns pc+1.
        @(negedge clk);
        inc = 0; call = 1; addr = 16'h0A00;
        @(posedge clk);
        #1;
        check_all(102, 16'h0A00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        call = 0; ret = 1;
        @(posedge clk);
        #1;
        check_all(103, 16'h0102, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        ret = 0; en = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
